int_issue_select: RTL and testbench
===================================

INT_ISSUE_SELECT -- requirements
Module: int_issue_select

Interface
REQ-001 Parameter QUEUE_SIZE, default 8, number of integer issue-queue entries.
REQ-002 Parameter ALIST_IDX, default 6, active-list id width.
REQ-003 Parameter PREG_IDX, default 6, physical register index width; DATA_W, default 32, data and address width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 entry_available_bit  in  QUEUE_SIZE  1 = slot free; 0 = slot occupied.
REQ-007 ready_bit_src1, ready_bit_src2  in  1 per entry  operand ready flags.
REQ-008 active_list_id  in  ALIST_IDX per entry  age tag of each entry.
REQ-009 payload in per entry: src1/src2 (PREG_IDX), immediate_data (DATA_W), alu_ctl, is_branch, prediction, recovery_target (DATA_W), uses_rs, uses_rt, uses_immediate.
REQ-010 alist_head  in  ALIST_IDX  id of the oldest in-flight instruction.
REQ-011 flush  in  1  branch recovery; kill the issue register.
REQ-012 ex_ready  in  1  ALU accepts the issue register this cycle.
REQ-013 issue_clear  out  QUEUE_SIZE  combinational one-hot of the entry leaving the queue this cycle; all zeros otherwise.
REQ-014 ex_valid  out  1  issue register holds a valid op.
REQ-015 ex_* payload  out  registered copy of the selected entry's payload plus ex_active_list_id.
REQ-016 stall_cycles  out  32  performance counter.

Function
REQ-017 Entry i SHALL be a candidate iff entry_available_bit[i]=0, ready_bit_src1[i]=1 and ready_bit_src2[i]=1.
REQ-018 Age of entry i SHALL be (active_list_id[i] - alist_head) mod 2^ALIST_IDX; the candidate with the smallest age SHALL be selected.
REQ-019 Equal ages SHALL resolve to the lowest index; this is illegal input, but the result is deterministic.
REQ-020 load = candidate_exists AND (!ex_valid OR ex_ready) AND !flush.
REQ-021 On load, issue_clear SHALL be the one-hot of the selected entry in the same cycle, and the issue register SHALL capture that entry's payload at the next edge.
REQ-022 When not loading, issue_clear SHALL be 0.
REQ-023 Issue register latency: queue entry to ex_valid is 1 cycle; throughput is 1 op per cycle while ex_ready=1.
REQ-024 Handshake: an op SHALL be consumed when ex_valid AND ex_ready; ex_* SHALL hold stable while ex_valid AND !ex_ready.
REQ-025 Consume with no load: ex_valid SHALL go to 0 next cycle. Consume and load in the same cycle: the new op SHALL replace the old back-to-back.
REQ-026 Flush SHALL have priority over everything: ex_valid SHALL be 0 next cycle, issue_clear SHALL be 0, and ex_ready SHALL be ignored.
REQ-027 Wakeups arriving this cycle SHALL NOT be seen; only the current ready bits count. An empty queue or no candidate SHALL produce no load.
REQ-028 Age arithmetic SHALL wrap modulo 2^ALIST_IDX; head=62 with ids {63,0,1} selects id 63.
REQ-029 stall_cycles SHALL increment by 1 each cycle with ex_valid=1 and ex_ready=0 and flush=0, saturating at 0xFFFFFFFF.

Reset
REQ-030 While rst_n=0 at an edge: ex_valid=0, all ex_* = 0, ex_alu_ctl=ALUCTL_NOP, ex_prediction=TAKEN, stall_cycles=0.
REQ-031 issue_clear SHALL be 0 whenever rst_n=0.
REQ-032 Reset mid-stall SHALL discard the held op; there SHALL be no output until the first edge after reset is released.

Verification
REQ-033 Entries 2 (id 5) and 6 (id 3) ready, head=0, ex_ready=1 -> issue_clear=0b01000000; next cycle ex_valid=1, ex_active_list_id=3.
REQ-034 head=62, ready ids 1/63/0 in slots 0/1/2 -> slot 1 selected, then slot 2, then slot 0 on consecutive cycles.
REQ-035 ex_valid=1, ex_ready=0 for 4 cycles with candidates present -> issue_clear=0 and ex_* stable throughout; stall_cycles increases by 4.
REQ-036 flush=1 while ex_valid=1 and a candidate is present -> issue_clear=0; ex_valid=0 next cycle.
REQ-037 Occupied entry with ready_bit_src2=0 only -> never selected; ex_valid stays 0.
REQ-038 rst_n=0 asserted while ex_valid=1 and stalled -> after one edge ex_valid=0 and stall_cycles=0.

Source files
------------

// File: rtl/int_issue_select_if.sv
// Issue-register bus between the integer issue select stage and the ALU.
//
// Signals:
//   ex_valid              issue register holds a valid op
//   ex_ready              ALU accepts the issue register this cycle
//   ex_src1, ex_src2      physical source register indices
//   ex_immediate_data     immediate operand
//   ex_alu_ctl            ALU operation code
//   ex_is_branch          op is a branch
//   ex_prediction         branch prediction bit (1 = taken)
//   ex_recovery_target    branch recovery address
//   ex_uses_rs/rt/immediate  operand usage flags
//   ex_active_list_id     active-list tag of the op
//
// Modports: master = issue stage (drives ex_*, reads ex_ready),
//           slave  = ALU (reads ex_*, drives ex_ready).
interface int_issue_select_if #(
    parameter int ALIST_IDX = 6,
    parameter int PREG_IDX  = 6,
    parameter int DATA_W    = 32
);
    logic                 ex_valid;
    logic                 ex_ready;
    logic [PREG_IDX-1:0]  ex_src1;
    logic [PREG_IDX-1:0]  ex_src2;
    logic [DATA_W-1:0]    ex_immediate_data;
    logic [3:0]           ex_alu_ctl;
    logic                 ex_is_branch;
    logic                 ex_prediction;
    logic [DATA_W-1:0]    ex_recovery_target;
    logic                 ex_uses_rs;
    logic                 ex_uses_rt;
    logic                 ex_uses_immediate;
    logic [ALIST_IDX-1:0] ex_active_list_id;

    modport master (
        output ex_valid,
        output ex_src1,
        output ex_src2,
        output ex_immediate_data,
        output ex_alu_ctl,
        output ex_is_branch,
        output ex_prediction,
        output ex_recovery_target,
        output ex_uses_rs,
        output ex_uses_rt,
        output ex_uses_immediate,
        output ex_active_list_id,
        input  ex_ready
    );

    modport slave (
        input  ex_valid,
        input  ex_src1,
        input  ex_src2,
        input  ex_immediate_data,
        input  ex_alu_ctl,
        input  ex_is_branch,
        input  ex_prediction,
        input  ex_recovery_target,
        input  ex_uses_rs,
        input  ex_uses_rt,
        input  ex_uses_immediate,
        input  ex_active_list_id,
        output ex_ready
    );
endinterface

// File: rtl/int_issue_select.sv
// Integer issue select: picks the oldest ready entry of the integer issue
// queue, clears it from the queue and loads it into a one-entry issue
// register feeding the ALU through a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   entry_available_bit   per entry, 1 = free slot
//   ready_bit_src1/2      per entry operand ready flags
//   active_list_id        per entry age tag
//   src1 .. uses_immediate  per entry payload
//   alist_head            id of the oldest in-flight instruction
//   flush                 branch recovery, kills the issue register
//   issue_clear           one-hot of the entry leaving the queue this cycle
//   ex                    issue register bus (master side)
//   stall_cycles          count of cycles the ALU back-pressured a valid op
module int_issue_select #(
    parameter int QUEUE_SIZE = 8,
    parameter int ALIST_IDX  = 6,
    parameter int PREG_IDX   = 6,
    parameter int DATA_W     = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [QUEUE_SIZE-1:0]                 entry_available_bit,
    input  logic [QUEUE_SIZE-1:0]                 ready_bit_src1,
    input  logic [QUEUE_SIZE-1:0]                 ready_bit_src2,
    input  logic [QUEUE_SIZE-1:0][ALIST_IDX-1:0]  active_list_id,
    input  logic [QUEUE_SIZE-1:0][PREG_IDX-1:0]   src1,
    input  logic [QUEUE_SIZE-1:0][PREG_IDX-1:0]   src2,
    input  logic [QUEUE_SIZE-1:0][DATA_W-1:0]     immediate_data,
    input  logic [QUEUE_SIZE-1:0][3:0]            alu_ctl,
    input  logic [QUEUE_SIZE-1:0]                 is_branch,
    input  logic [QUEUE_SIZE-1:0]                 prediction,
    input  logic [QUEUE_SIZE-1:0][DATA_W-1:0]     recovery_target,
    input  logic [QUEUE_SIZE-1:0]                 uses_rs,
    input  logic [QUEUE_SIZE-1:0]                 uses_rt,
    input  logic [QUEUE_SIZE-1:0]                 uses_immediate,
    input  logic [ALIST_IDX-1:0]                  alist_head,
    input  logic                                  flush,
    output logic [QUEUE_SIZE-1:0]                 issue_clear,
    int_issue_select_if.master                    ex,
    output logic [31:0]                           stall_cycles
);

    localparam int         IDX_W      = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
    localparam logic [3:0] ALUCTL_NOP = 4'hF;
    localparam logic       TAKEN      = 1'b1;

    logic [QUEUE_SIZE-1:0]                candidate;
    logic [QUEUE_SIZE-1:0][ALIST_IDX-1:0] age;
    logic                                 found;
    logic [IDX_W-1:0]                     sel_idx;
    logic [ALIST_IDX-1:0]                 best_age;
    logic                                 load;
    logic                                 consume;

    assign candidate = ~entry_available_bit & ready_bit_src1 & ready_bit_src2;

    // Age relative to the head; the subtraction wraps at the tag width so
    // tags that have rolled over past zero still compare as younger.
    always_comb begin
        for (int unsigned i = 0; i < QUEUE_SIZE; i++) begin
            age[i] = active_list_id[i] - alist_head;
        end
    end

    // Strict less-than keeps the lowest index on equal ages.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        best_age = '0;
        for (int unsigned i = 0; i < QUEUE_SIZE; i++) begin
            if (candidate[i] && (!found || (age[i] < best_age))) begin
                found    = 1'b1;
                sel_idx  = IDX_W'(i);
                best_age = age[i];
            end
        end
    end

    assign consume = ex.ex_valid & ex.ex_ready;
    // rst_n gates the load so the queue never sees a clear during reset.
    assign load    = found & (~ex.ex_valid | ex.ex_ready) & ~flush & rst_n;

    always_comb begin
        issue_clear = '0;
        if (load) begin
            issue_clear[sel_idx] = 1'b1;
        end
    end

    // Issue register: reset, then flush, then load, then drain on consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex.ex_valid           <= 1'b0;
            ex.ex_src1            <= '0;
            ex.ex_src2            <= '0;
            ex.ex_immediate_data  <= '0;
            ex.ex_alu_ctl         <= ALUCTL_NOP;
            ex.ex_is_branch       <= 1'b0;
            ex.ex_prediction      <= TAKEN;
            ex.ex_recovery_target <= '0;
            ex.ex_uses_rs         <= 1'b0;
            ex.ex_uses_rt         <= 1'b0;
            ex.ex_uses_immediate  <= 1'b0;
            ex.ex_active_list_id  <= '0;
        end else if (flush) begin
            ex.ex_valid <= 1'b0;
        end else if (load) begin
            ex.ex_valid           <= 1'b1;
            ex.ex_src1            <= src1[sel_idx];
            ex.ex_src2            <= src2[sel_idx];
            ex.ex_immediate_data  <= immediate_data[sel_idx];
            ex.ex_alu_ctl         <= alu_ctl[sel_idx];
            ex.ex_is_branch       <= is_branch[sel_idx];
            ex.ex_prediction      <= prediction[sel_idx];
            ex.ex_recovery_target <= recovery_target[sel_idx];
            ex.ex_uses_rs         <= uses_rs[sel_idx];
            ex.ex_uses_rt         <= uses_rt[sel_idx];
            ex.ex_uses_immediate  <= uses_immediate[sel_idx];
            ex.ex_active_list_id  <= active_list_id[sel_idx];
        end else if (consume) begin
            ex.ex_valid <= 1'b0;
        end
    end

    // Back-pressure counter, saturating rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (ex.ex_valid && !ex.ex_ready && !flush && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_int_issue_select.sv
module tb_int_issue_select;

    localparam int QS = 8;

    typedef struct packed {
        logic [5:0]  src1;
        logic [5:0]  src2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        br;
        logic        pred;
        logic [31:0] rt;
        logic        urs;
        logic        urt;
        logic        uimm;
        logic [5:0]  id;
    } ent_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [QS-1:0]         entry_available_bit;
    logic [QS-1:0]         ready_bit_src1;
    logic [QS-1:0]         ready_bit_src2;
    logic [QS-1:0][5:0]    active_list_id;
    logic [QS-1:0][5:0]    src1;
    logic [QS-1:0][5:0]    src2;
    logic [QS-1:0][31:0]   immediate_data;
    logic [QS-1:0][3:0]    alu_ctl;
    logic [QS-1:0]         is_branch;
    logic [QS-1:0]         prediction;
    logic [QS-1:0][31:0]   recovery_target;
    logic [QS-1:0]         uses_rs;
    logic [QS-1:0]         uses_rt;
    logic [QS-1:0]         uses_immediate;
    logic [5:0]            alist_head;
    logic                  flush;
    logic [QS-1:0]         issue_clear;
    logic [31:0]           stall_cycles;

    int_issue_select_if #(.ALIST_IDX(6), .PREG_IDX(6), .DATA_W(32)) bus ();

    int_issue_select #(
        .QUEUE_SIZE(QS),
        .ALIST_IDX(6),
        .PREG_IDX(6),
        .DATA_W(32)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .entry_available_bit (entry_available_bit),
        .ready_bit_src1      (ready_bit_src1),
        .ready_bit_src2      (ready_bit_src2),
        .active_list_id      (active_list_id),
        .src1                (src1),
        .src2                (src2),
        .immediate_data      (immediate_data),
        .alu_ctl             (alu_ctl),
        .is_branch           (is_branch),
        .prediction          (prediction),
        .recovery_target     (recovery_target),
        .uses_rs             (uses_rs),
        .uses_rt             (uses_rt),
        .uses_immediate      (uses_immediate),
        .alist_head          (alist_head),
        .flush               (flush),
        .issue_clear         (issue_clear),
        .ex                  (bus),
        .stall_cycles        (stall_cycles)
    );

    always #5 clk = ~clk;

    // Queue contents as the bench sees them.
    ent_t       q   [QS];
    logic       occ [QS];
    logic       r1  [QS];
    logic       r2  [QS];
    logic [5:0] head;

    int checks   = 0;
    int failures = 0;

    ent_t rst_ent;
    ent_t got;

    function automatic ent_t rand_ent(input logic [5:0] id);
        ent_t e;
        e.src1 = 6'($urandom);
        e.src2 = 6'($urandom);
        e.imm  = $urandom;
        e.alu  = 4'($urandom);
        e.br   = 1'($urandom);
        e.pred = 1'($urandom);
        e.rt   = $urandom;
        e.urs  = 1'($urandom);
        e.urt  = 1'($urandom);
        e.uimm = 1'($urandom);
        e.id   = id;
        return e;
    endfunction

    // Reference pick: scan ages from oldest upward, first slot found wins.
    function automatic int pick_oldest();
        for (int a = 0; a < 64; a++) begin
            for (int i = 0; i < QS; i++) begin
                if (occ[i] && r1[i] && r2[i] &&
                    (((int'(q[i].id) - int'(head)) + 64) % 64 == a)) begin
                    return i;
                end
            end
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < QS; i++) begin
            entry_available_bit[i] = !occ[i];
            ready_bit_src1[i]      = r1[i];
            ready_bit_src2[i]      = r2[i];
            active_list_id[i]      = q[i].id;
            src1[i]                = q[i].src1;
            src2[i]                = q[i].src2;
            immediate_data[i]      = q[i].imm;
            alu_ctl[i]             = q[i].alu;
            is_branch[i]           = q[i].br;
            prediction[i]          = q[i].pred;
            recovery_target[i]     = q[i].rt;
            uses_rs[i]             = q[i].urs;
            uses_rt[i]             = q[i].urt;
            uses_immediate[i]      = q[i].uimm;
        end
        alist_head = head;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        got = {bus.ex_src1, bus.ex_src2, bus.ex_immediate_data, bus.ex_alu_ctl,
               bus.ex_is_branch, bus.ex_prediction, bus.ex_recovery_target,
               bus.ex_uses_rs, bus.ex_uses_rt, bus.ex_uses_immediate,
               bus.ex_active_list_id};
    endtask

    task automatic set_slot(input int i, input logic [5:0] id);
        q[i]   = rand_ent(id);
        occ[i] = 1'b1;
        r1[i]  = 1'b1;
        r2[i]  = 1'b1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        flush       = 1'b0;
        bus.ex_ready = 1'b1;
        head        = '0;
        for (int i = 0; i < QS; i++) begin
            occ[i] = 1'b0; r1[i] = 1'b0; r2[i] = 1'b0; q[i] = '0;
        end
        drive();
        tick();
        rst_n = 1'b1;
        drive();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.ex_ready = 1'b1;
        head = '0;
        for (int i = 0; i < QS; i++) begin
            occ[i] = 1'b0; r1[i] = 1'b0; r2[i] = 1'b0; q[i] = '0;
        end
        set_slot(4, 6'd9);
        drive();
        tick();
        tick();
        checks++;
        if (issue_clear !== '0) begin
            failures++;
            $display("FAIL reset_clear got=%b exp=%b", issue_clear, {QS{1'b0}});
        end
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", bus.ex_valid);
        end
        sample();
        checks++;
        if (got !== rst_ent) begin
            failures++;
            $display("FAIL reset_payload got=%h exp=%h", got, rst_ent);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
        end
    endtask

    task automatic test_age_select();
        do_reset();
        set_slot(2, 6'd5);
        set_slot(6, 6'd3);
        drive();
        #1;
        checks++;
        if (issue_clear !== 8'b0100_0000) begin
            failures++;
            $display("FAIL age_clear1 got=%b exp=01000000", issue_clear);
        end
        tick();
        occ[6] = 1'b0;
        drive();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_active_list_id !== 6'd3) begin
            failures++;
            $display("FAIL age_issue1 got=%b/%0d exp=1/3", bus.ex_valid, bus.ex_active_list_id);
        end
        #1;
        checks++;
        if (issue_clear !== 8'b0000_0100) begin
            failures++;
            $display("FAIL age_clear2 got=%b exp=00000100", issue_clear);
        end
        tick();
        occ[2] = 1'b0;
        drive();
        sample();
        checks++;
        if (bus.ex_valid !== 1'b1 || got !== q[2]) begin
            failures++;
            $display("FAIL age_issue2 got=%b/%h exp=1/%h", bus.ex_valid, got, q[2]);
        end
    endtask

    task automatic test_wrap();
        logic [QS-1:0] exp_clear [3];
        int            exp_slot  [3];
        logic [5:0]    exp_id    [3];
        exp_clear[0] = 8'b0000_0010; exp_slot[0] = 1; exp_id[0] = 6'd63;
        exp_clear[1] = 8'b0000_0100; exp_slot[1] = 2; exp_id[1] = 6'd0;
        exp_clear[2] = 8'b0000_0001; exp_slot[2] = 0; exp_id[2] = 6'd1;
        do_reset();
        head = 6'd62;
        set_slot(0, 6'd1);
        set_slot(1, 6'd63);
        set_slot(2, 6'd0);
        for (int k = 0; k < 3; k++) begin
            drive();
            #1;
            checks++;
            if (issue_clear !== exp_clear[k]) begin
                failures++;
                $display("FAIL wrap_clear%0d got=%b exp=%b", k, issue_clear, exp_clear[k]);
            end
            tick();
            occ[exp_slot[k]] = 1'b0;
            checks++;
            if (bus.ex_valid !== 1'b1 || bus.ex_active_list_id !== exp_id[k]) begin
                failures++;
                $display("FAIL wrap_issue%0d got=%b/%0d exp=1/%0d", k, bus.ex_valid,
                         bus.ex_active_list_id, exp_id[k]);
            end
        end
    endtask

    task automatic test_stall();
        ent_t held;
        do_reset();
        set_slot(0, 6'd7);
        drive();
        tick();
        held   = q[0];
        occ[0] = 1'b0;
        set_slot(1, 6'd8);
        bus.ex_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive();
            #1;
            checks++;
            if (issue_clear !== '0) begin
                failures++;
                $display("FAIL stall_clear%0d got=%b exp=0", k, issue_clear);
            end
            tick();
            sample();
            checks++;
            if (bus.ex_valid !== 1'b1 || got !== held) begin
                failures++;
                $display("FAIL stall_hold%0d got=%b/%h exp=1/%h", k, bus.ex_valid, got, held);
            end
        end
        checks++;
        if (stall_cycles !== 32'd4) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=4", stall_cycles);
        end
        bus.ex_ready = 1'b1;
        drive();
        #1;
        checks++;
        if (issue_clear !== 8'b0000_0010) begin
            failures++;
            $display("FAIL b2b_clear got=%b exp=00000010", issue_clear);
        end
        tick();
        occ[1] = 1'b0;
        drive();
        sample();
        checks++;
        if (bus.ex_valid !== 1'b1 || got !== q[1]) begin
            failures++;
            $display("FAIL b2b_issue got=%b/%h exp=1/%h", bus.ex_valid, got, q[1]);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_valid got=%b exp=0", bus.ex_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_slot(0, 6'd10);
        drive();
        tick();
        occ[0] = 1'b0;
        set_slot(1, 6'd11);
        bus.ex_ready = 1'b0;
        flush = 1'b1;
        drive();
        #1;
        checks++;
        if (issue_clear !== '0) begin
            failures++;
            $display("FAIL flush_clear got=%b exp=0", issue_clear);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL flush_kill got=%b/%0d exp=0/0", bus.ex_valid, stall_cycles);
        end
        flush = 1'b0;
        drive();
        #1;
        checks++;
        if (issue_clear !== 8'b0000_0010) begin
            failures++;
            $display("FAIL flush_after got=%b exp=00000010", issue_clear);
        end
        tick();
        occ[1] = 1'b0;
        drive();
    endtask

    task automatic test_not_ready();
        do_reset();
        set_slot(3, 6'd2);
        r2[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive();
            #1;
            checks++;
            if (issue_clear !== '0) begin
                failures++;
                $display("FAIL notready_clear%0d got=%b exp=0", k, issue_clear);
            end
            tick();
            checks++;
            if (bus.ex_valid !== 1'b0) begin
                failures++;
                $display("FAIL notready_valid%0d got=%b exp=0", k, bus.ex_valid);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_slot(0, 6'd20);
        drive();
        tick();
        occ[0] = 1'b0;
        set_slot(5, 6'd21);
        bus.ex_ready = 1'b0;
        drive();
        tick();
        tick();
        checks++;
        if (stall_cycles !== 32'd2) begin
            failures++;
            $display("FAIL rstmid_pre got=%0d exp=2", stall_cycles);
        end
        rst_n = 1'b0;
        drive();
        #1;
        checks++;
        if (issue_clear !== '0) begin
            failures++;
            $display("FAIL rstmid_clear got=%b exp=0", issue_clear);
        end
        tick();
        sample();
        checks++;
        if (bus.ex_valid !== 1'b0 || stall_cycles !== 32'd0 || got !== rst_ent) begin
            failures++;
            $display("FAIL rstmid_state got=%b/%0d/%h exp=0/0/%h", bus.ex_valid,
                     stall_cycles, got, rst_ent);
        end
        rst_n = 1'b1;
        drive();
        #1;
        checks++;
        if (issue_clear !== 8'b0010_0000) begin
            failures++;
            $display("FAIL rstmid_release got=%b exp=00100000", issue_clear);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_active_list_id !== 6'd21) begin
            failures++;
            $display("FAIL rstmid_issue got=%b/%0d exp=1/21", bus.ex_valid, bus.ex_active_list_id);
        end
        bus.ex_ready = 1'b1;
        occ[5] = 1'b0;
        drive();
    endtask

    task automatic test_random();
        logic          mv;
        ent_t          mp;
        longint        mstall;
        int            sel;
        logic          ld;
        logic [QS-1:0] exp_clear;
        do_reset();
        mv     = 1'b0;
        mp     = '0;
        mstall = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < QS; i++) begin
                if (!occ[i] && ($urandom % 3 == 0)) begin
                    q[i]   = rand_ent(6'($urandom));
                    occ[i] = 1'b1;
                end
                r1[i] = ($urandom % 4 != 0);
                r2[i] = ($urandom % 4 != 0);
            end
            if ($urandom % 8 == 0) head = 6'($urandom);
            flush        = ($urandom % 10 == 0);
            bus.ex_ready = ($urandom % 3 != 0);
            drive();
            #1;
            sel = pick_oldest();
            ld  = (sel >= 0) && (!mv || bus.ex_ready) && !flush;
            exp_clear = '0;
            if (ld) exp_clear[sel] = 1'b1;
            checks++;
            if (issue_clear !== exp_clear) begin
                failures++;
                $display("FAIL rand_clear cyc=%0d got=%b exp=%b", cyc, issue_clear, exp_clear);
            end
            if (mv && !bus.ex_ready && !flush && mstall < 64'hFFFF_FFFF) mstall++;
            if (flush)                    mv = 1'b0;
            else if (ld) begin            mv = 1'b1; mp = q[sel]; end
            else if (mv && bus.ex_ready)  mv = 1'b0;
            tick();
            if (ld) occ[sel] = 1'b0;
            sample();
            checks++;
            if (bus.ex_valid !== mv || (mv && got !== mp)) begin
                failures++;
                $display("FAIL rand_ex cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.ex_valid, got, mv, mp);
            end
            checks++;
            if (stall_cycles !== 32'(mstall)) begin
                failures++;
                $display("FAIL rand_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cycles, mstall);
            end
        end
    endtask

    initial begin
        rst_ent      = '0;
        rst_ent.alu  = 4'hF;
        rst_ent.pred = 1'b1;
        test_reset();
        test_age_select();
        test_wrap();
        test_stall();
        test_flush();
        test_not_ready();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
